// File: rtl/lf356_array.sv
// Bank of slew-limited, rail-clamped op-amp channels (follower/difference).
// Optional per-channel input offset port under LF356_ARRAY_OFFSET_EN.
module lf356_array #(
    parameter int NCH  = 4,
    parameter int W    = 12,
    parameter int SLEW = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic [NCH-1:0]      MODE,
    input  logic [NCH*W-1:0]    PIN,
    input  logic [NCH*W-1:0]    NIN,
    input  logic [W-1:0]        PVSS,
    input  logic [W-1:0]        NVSS,
`ifdef LF356_ARRAY_OFFSET_EN
    input  logic [NCH*W-1:0]    OFFSET,
`endif
    output logic [NCH*W-1:0]    OUT,
    output logic [NCH-1:0]      SETTLED,
    output logic                RAIL_FAULT
);

    localparam logic [W-1:0]        STEP = W'(SLEW);
    localparam logic signed [W:0]   LIM  = (W+1)'(SLEW);

    logic [NCH-1:0][W-1:0] out_q, out_d;
    logic [NCH-1:0]        set_q, set_d;
    logic                  flt_q, flt_d;

    logic [W-1:0]          p, n, o;
    logic signed [W+1:0]   base, off, raw, hi, lo;
    logic signed [W-1:0]   tgt;
    logic signed [W:0]     dif;

    always_comb begin
        out_d = out_q;
        set_d = set_q;
        p     = '0;
        n     = '0;
        o     = '0;
        base  = '0;
        off   = '0;
        raw   = '0;
        tgt   = '0;
        dif   = '0;
        flt_d = $signed(NVSS) > $signed(PVSS);
        hi    = {{2{PVSS[W-1]}}, PVSS};
        lo    = {{2{NVSS[W-1]}}, NVSS};
        for (int i = 0; i < NCH; i++) begin
            p = PIN[i*W +: W];
            n = NIN[i*W +: W];
            o = out_q[i];
            if (MODE[i])
                base = {{2{p[W-1]}}, p} - {{2{n[W-1]}}, n};
            else
                base = {{2{p[W-1]}}, p};
`ifdef LF356_ARRAY_OFFSET_EN
            off = {{2{OFFSET[i*W+W-1]}}, OFFSET[i*W +: W]};
`else
            off = '0;
`endif
            raw = base + off;
            // Saturate into the rails; the result always fits in W bits.
            if (raw > hi)
                tgt = hi[W-1:0];
            else if (raw < lo)
                tgt = lo[W-1:0];
            else
                tgt = raw[W-1:0];
            dif = {tgt[W-1], tgt} - {o[W-1], o};
            if (dif > LIM)
                out_d[i] = o + STEP;
            else if (dif < -LIM)
                out_d[i] = o - STEP;
            else
                out_d[i] = tgt;
            set_d[i] = (out_d[i] == tgt);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q <= '0;
            set_q <= '0;
            flt_q <= 1'b0;
        end else begin
            flt_q <= flt_d;
            if (EN && !flt_d) begin
                out_q <= out_d;
                set_q <= set_d;
            end
        end
    end

    assign OUT        = out_q;
    assign SETTLED    = set_q;
    assign RAIL_FAULT = flt_q;

endmodule
